// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with single outstanding request and 2-entry queue
//
// Purpose: issues word-aligned instruction-memory reads, buffers returned words
// with their pc+4 in a 2-entry in-order queue, and presents the head entry to
// the decode register. Redirects flush the queue and restart fetch.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous, active-low reset
//   imem_req     request valid (high exactly in the REQ state)
//   imem_addr    fetch address, stable while imem_req=1
//   imem_gnt     request accepted this cycle
//   imem_rvalid  read data valid, one per granted request, in order
//   imem_rdata   instruction word qualified by imem_rvalid
//   stall        decode register not loading; head entry is kept
//   redirect     flush and refetch from redirect_pc
//   redirect_pc  new fetch address (bits [1:0] ignored)
//   InstrF       head instruction, zero when the queue is empty
//   PcF          head instruction address plus 4, zero when empty
//   validF       queue non-empty
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] InstrF,
    output logic [31:0] PcF,
    output logic        validF
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [1:0][31:0] instr_q, instr_d;
    logic [1:0][31:0] pc4_q, pc4_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             imem_req_q, imem_req_d;

    logic             push;
    logic             pop;
    logic [1:0]       count_post;

    always_comb begin
        pop        = (count_q != 2'd0) && !stall;
        // Only a response to a live (non-flushed) request in WAIT is kept.
        push       = (state_q == S_WAIT) && imem_rvalid && !redirect;
        count_post = count_q + {1'b0, push} - {1'b0, pop};

        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_post;

        // pc_q was advanced at grant time and any later redirect discards the
        // response, so in WAIT pc_q is exactly the request address plus 4.
        if (push) begin
            instr_d[wr_ptr_q] = imem_rdata;
            pc4_d[wr_ptr_q]   = pc_q;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!redirect && (count_q < 2'd2)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    state_d = imem_gnt ? S_DROP : S_IDLE;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                    pc_d    = pc_q + 32'd4;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? S_IDLE : S_DROP;
                end else if (imem_rvalid) begin
                    state_d = (count_post < 2'd2) ? S_REQ : S_IDLE;
                end
            end
            S_DROP: begin
                // Wait out the stale response of the flushed request.
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over any push/pop in the same cycle.
        if (redirect) begin
            pc_d     = redirect_pc & ~32'd3;
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end

        imem_req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc4_q      <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            imem_req_q <= imem_req_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign validF    = (count_q != 2'd0);
    assign InstrF    = validF ? instr_q[rd_ptr_q] : 32'h0;
    assign PcF       = validF ? pc4_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] InstrF;
    logic [31:0] PcF;
    logic        validF;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .InstrF      (InstrF),
        .PcF         (PcF),
        .validF      (validF)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    int          total = 0;
    int          bad = 0;
    int          pushes = 0;
    entry_t      mq[$];
    logic [31:0] fetch_addr = RESET_PC;
    bit          out_valid = 0;
    bit          out_stale = 0;
    logic [31:0] out_addr = 32'h0;
    int          out_delay = 0;
    int          max_dly = 0;
    bit          stray_en = 0;
    bit          force_stray = 0;
    logic [31:0] held_addr;
    bit          req_seen;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        entry_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        check("validF", 32'(validF), 32'(mq.size() != 0));
        check("InstrF", InstrF, h.instr);
        check("PcF", PcF, h.pc4);
        if (imem_req) check("imem_addr", imem_addr, fetch_addr);
        if (out_valid) check("req_while_outstanding", 32'(imem_req), 32'd0);
        if (mq.size() == 2) check("req_when_full", 32'(imem_req), 32'd0);
    endtask

    // One clock: drive the memory response, advance the reference model from
    // the protocol rules, clock the DUT, then compare on the falling edge.
    task automatic step();
        logic   granted;
        entry_t e;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (out_valid && out_delay == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(out_addr);
        end else if (!out_valid && (force_stray || (stray_en && $urandom_range(0, 7) == 0))) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end
        force_stray = 0;
        granted = imem_req && imem_gnt;
        if (redirect) begin
            mq.delete();
        end else begin
            if (mq.size() != 0 && !stall) void'(mq.pop_front());
            if (out_valid && out_delay == 0 && !out_stale) begin
                e.instr = mem_word(out_addr);
                e.pc4   = out_addr + 32'd4;
                mq.push_back(e);
                pushes++;
            end
        end
        if (out_valid) begin
            if (out_delay == 0) out_valid = 0;
            else begin
                out_delay--;
                out_stale = out_stale || redirect;
            end
        end
        if (granted) begin
            out_valid = 1;
            out_addr  = imem_addr;
            out_stale = redirect;
            out_delay = $urandom_range(0, max_dly);
        end
        if (redirect) fetch_addr = redirect_pc & ~32'd3;
        else if (granted) fetch_addr = fetch_addr + 32'd4;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_validF"}, 32'(validF), 32'd0);
        check({tag, "_InstrF"}, InstrF, 32'h0);
        check({tag, "_PcF"}, PcF, 32'h0);
    endtask

    initial begin
        logic [5:0] exp_req;
        logic [5:0] exp_val;
        exp_req = 6'b010101;
        exp_val = 6'b010100;

        // reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // back-to-back fetch, grant always, data one cycle after grant
        imem_gnt = 1'b1;
        max_dly  = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("seq_req%0d", k), 32'(imem_req), 32'(exp_req[k]));
            check($sformatf("seq_val%0d", k), 32'(validF), 32'(exp_val[k]));
        end

        // stall fills the queue and stops requests; release drains it
        max_dly = 2;
        stall   = 1'b1;
        repeat (12) step();
        check("stall_full_valid", 32'(validF), 32'd1);
        check("stall_full_req", 32'(imem_req), 32'd0);
        stall = 1'b0;
        repeat (8) step();

        // redirect while waiting for data, stale data two cycles after grant
        max_dly = 1;
        for (int i = 0; i < 20 && !(out_valid && out_delay == 1); i++) step();
        check("wait_found", 32'(out_valid && out_delay == 1), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check("redir_validF", 32'(validF), 32'd0);
        req_seen = 0;
        for (int i = 0; i < 10 && !req_seen; i++) begin
            step();
            req_seen = imem_req;
        end
        check("redir_req_seen", 32'(req_seen), 32'd1);
        check("redir_addr", imem_addr, 32'h100);

        // grant withheld: request held stable, then redirected away
        imem_gnt = 1'b0;
        req_seen = imem_req;
        for (int i = 0; i < 10 && !req_seen; i++) begin
            step();
            req_seen = imem_req;
        end
        check("nognt_req_seen", 32'(req_seen), 32'd1);
        held_addr = imem_addr;
        for (int i = 0; i < 5; i++) begin
            step();
            check("nognt_req_hold", 32'(imem_req), 32'd1);
            check("nognt_addr_hold", imem_addr, held_addr);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        check("nognt_redir_req", 32'(imem_req), 32'd0);
        step();
        check("nognt_redir_req2", 32'(imem_req), 32'd1);
        check("nognt_redir_addr", imem_addr, 32'h200);
        imem_gnt = 1'b1;

        // randomized traffic
        max_dly  = 3;
        stray_en = 1;
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            imem_gnt    = ($urandom_range(0, 9) < 6);
            step();
        end
        redirect = 1'b0;
        stray_en = 0;

        // reset while a request is outstanding and the queue holds data
        stall    = 1'b1;
        imem_gnt = 1'b1;
        for (int i = 0; i < 50 && !(out_valid && mq.size() != 0); i++) step();
        check("wait_valid_found", 32'(out_valid && mq.size() != 0), 32'd1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_reset");
        mq.delete();
        out_valid  = 0;
        fetch_addr = RESET_PC;
        stall      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_reset_outputs("release");
        force_stray = 1;
        step();
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", imem_addr, RESET_PC);
        repeat (20) step();

        check("progress", 32'(pushes > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
